fetch_controller: RTL and testbench

//  Sequences the instruction memory for the IF stage. Owns the fetch PC and drives the synchronous

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 77 +++++++
 rtl/fetch_controller.sv | 95 +++++++++
 tb/tb_fetch_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, NOP encoding, PC increment, fetch entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order FIFO of fetched {pc, instr} entries with a registered head so decode never sees
// a combinational path from the push data.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output logic             head_valid_o,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  fetch_entry_t     head_q, head_d;

  // Head is precomputed from the post-edge view; a push into an emptying buffer bypasses storage.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d      = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      head_valid_d = (count_d != '0);
      if (count_d != '0) begin
        if (push_i && (count_q == CNT_W'(pop_i))) head_d = push_data_i;
        else                                      head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '{pc: '0, instr: INSTR_NOP};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the fetch PC, drives the synchronous imem address, tracks the one
// outstanding read and feeds returned words through fetch_buffer to decode.
module fetch_controller
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_read_address,
  input  logic [XLEN-1:0] imem_instruction_in,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic             inflight;
  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] buf_count;
  logic             head_valid;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign inflight   = (state_q == ST_WAIT);
  assign pop        = head_valid & if_ready & ~redirect_valid;
  assign push       = inflight & ~redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_instruction_in};

  // Reserve a slot for every word already requested so the buffer can never overflow.
  assign occupancy = OCC_W'(buf_count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = fetch_en & ~redirect_valid & (occupancy < OCC_W'(BUF_DEPTH));

  always_comb begin
    state_d       = ST_IDLE;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      state_d       = ST_WAIT;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_fetch_buffer (
    .clk          (clk),
    .rst_n        (reset),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_o       (head),
    .count_o      (buf_count)
  );

  assign imem_read_address = pc_q;
  assign if_valid          = head_valid;
  assign if_pc             = head.pc;
  assign if_instr          = head.instr;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: synchronous imem model, queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_controller;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_read_address;
  logic [31:0] imem_instruction_in;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_en            (fetch_en),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .imem_read_address   (imem_read_address),
    .imem_instruction_in (imem_instruction_in),
    .if_valid            (if_valid),
    .if_pc               (if_pc),
    .if_instr            (if_instr),
    .if_ready            (if_ready)
  );

  // Memory word i holds 0x1000_0000 + i.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) imem_instruction_in <= word_at(imem_read_address);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of delivered PCs plus the one outstanding request.
  logic [31:0] m_pc, m_infl_pc, e_pc, e_instr;
  logic [31:0] q[$];
  bit          m_infl, e_valid, m_pop, m_issue;
  int          m_occ;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h0; m_infl = 1'b0; m_infl_pc = 32'h0;
      q.delete();
      e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0000_0013;
    end else begin
      m_pop = e_valid && if_ready;
      if (redirect_valid) begin
        q.delete();
        m_infl = 1'b0;
        m_pc   = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        m_occ   = q.size() + int'(m_infl) - int'(m_pop);
        m_issue = fetch_en && (m_occ < int'(DEPTH));
        if (m_pop) void'(q.pop_front());
        if (m_infl) q.push_back(m_infl_pc);
        m_infl = m_issue;
        if (m_issue) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
      e_valid = (q.size() != 0);
      if (e_valid) begin
        e_pc    = q[0];
        e_instr = word_at(q[0]);
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_if_valid", 32'(if_valid), 32'(e_valid));
      chk("model_if_pc", if_pc, e_pc);
      chk("model_if_instr", if_instr, e_instr);
      chk("model_imem_addr", imem_read_address, m_pc);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    cyc(3);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_addr", imem_read_address, 32'h0);
    chk_en = 1'b1;

    // Cycle 0: release reset with fetch and decode ready.
    reset = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    cyc(1); chk("c1_addr", imem_read_address, 32'h4); chk("c1_valid", 32'(if_valid), 32'h0);
    cyc(1); chk("c2_valid", 32'(if_valid), 32'h1); chk("c2_pc", if_pc, 32'h0);
    chk("c2_instr", if_instr, 32'h1000_0000);
    cyc(1); chk("c3_pc", if_pc, 32'h4); chk("c3_instr", if_instr, 32'h1000_0001);
    cyc(1); chk("c4_pc", if_pc, 32'h8); chk("c4_instr", if_instr, 32'h1000_0002);
    cyc(1); chk("c5_pc", if_pc, 32'hC); chk("c5_instr", if_instr, 32'h1000_0003);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc(1); redirect_valid = 1'b0;
    chk("c6_addr", imem_read_address, 32'h40); chk("c6_valid", 32'(if_valid), 32'h0);
    cyc(1); chk("c7_valid", 32'(if_valid), 32'h0);
    cyc(1); chk("c8_valid", 32'(if_valid), 32'h1); chk("c8_pc", if_pc, 32'h40);
    chk("c8_instr", if_instr, 32'h1000_0010);

    // Decode stalls for five cycles: head and address must hold.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_pc", if_pc, 32'h40);
      chk("stall_addr", imem_read_address, 32'h48);
    end
    if_ready = 1'b1;
    cyc(1); chk("rel_pc0", if_pc, 32'h44);
    cyc(1); chk("rel_pc1", if_pc, 32'h48);
    cyc(1); chk("rel_pc2", if_pc, 32'h4C);

    // Fill the buffer, then redirect to an unaligned target while popping.
    if_ready = 1'b0;
    cyc(2);
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
    cyc(1); redirect_valid = 1'b0;
    chk("unal_addr", imem_read_address, 32'h40);
    cyc(2); chk("unal_pc", if_pc, 32'h40); chk("unal_instr", if_instr, 32'h1000_0010);

    // Fetch disabled for three cycles mid-stream.
    cyc(2); fetch_en = 1'b0;
    cyc(1); chk("fen_pc", if_pc, 32'h4C); chk("fen_addr", imem_read_address, 32'h50);
    cyc(1); chk("fen_valid", 32'(if_valid), 32'h0); chk("fen_addr2", imem_read_address, 32'h50);
    cyc(1); fetch_en = 1'b1;
    cyc(2); chk("fen_resume_pc", if_pc, 32'h50); chk("fen_resume_instr", if_instr, 32'h1000_0014);

    // Reset pulse while the buffer holds data and a read is outstanding.
    if_ready = 1'b0;
    cyc(1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(if_valid), 32'h0);
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_instr", if_instr, 32'h0000_0013);
    chk("arst_addr", imem_read_address, 32'h0);
    cyc(1); reset = 1'b1; if_ready = 1'b1;
    cyc(2); chk("arst_refetch_pc", if_pc, 32'h0); chk("arst_refetch_instr", if_instr, 32'h1000_0000);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      fetch_en       = ($urandom_range(0, 9) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31)))
                                                   : $urandom;
      #2 reset = ($urandom_range(0, 199) != 0);
    end
    cyc(1); reset = 1'b1;
    cyc(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
